// File: rtl/matrix_pkg.sv
// Shared constants and collector state encoding
// for the matrix result collection path.
package matrix_pkg;

    localparam int P_WIDTH = 18;
    localparam int NUM_P   = 4;
    localparam int SEL_W   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_SWEEP = 2'd2
    } coll_state_e;

    // Free FIFO slots given depth and occupancy.
    function automatic int unsigned free_slots(
        input int unsigned depth,
        input int unsigned occ
    );
        return depth - occ;
    endfunction

endpackage

// File: rtl/matrix_result_fifo.sv
// Show-ahead result FIFO with synchronous flush.
// Ports: clk, rst, flush, push/wr_data, pop, rd_data, rd_valid, count.
module matrix_result_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 18,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_pop;
    logic             do_push;
    logic             full;

    assign full     = (count == CW'(DEPTH));
    assign rd_valid = (count != '0);
    assign rd_data  = mem[rd_ptr];
    assign do_pop   = pop & rd_valid;
    // A pop in the same cycle frees the slot being written.
    assign do_push  = push & (~full | do_pop);

    // Storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/matrix_result_collector.sv
// Sweeps matrixTOP products into a result FIFO, stalling on lack of space.
// Ports: result_valid/P_out/P_sel/hold to matrixTOP; rd_* consumer side; count, overflow.
module matrix_result_collector #(
    parameter int DEPTH   = 16,
    parameter int P_WIDTH = matrix_pkg::P_WIDTH,
    parameter int NUM_P   = matrix_pkg::NUM_P,
    localparam int CW     = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               result_valid,
    input  logic [P_WIDTH-1:0] P_out,
    output logic [1:0]         P_sel,
    output logic               hold,
    input  logic               clear,
    output logic [P_WIDTH-1:0] rd_data,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [CW-1:0]      count,
    output logic               overflow
);

    import matrix_pkg::*;

    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_P - 1);

    coll_state_e      state;
    coll_state_e      state_nx;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_nx;
    logic             push;
    logic             lost;
    logic             room;
    logic [CW-1:0]    free_words;

    // Space is judged on occupancy before any same-cycle pop.
    assign free_words = CW'(free_slots(DEPTH, 32'(count)));
    assign room       = (free_words >= CW'(NUM_P));

    always_comb begin
        state_nx = state;
        sel_nx   = sel_q;
        push     = 1'b0;
        lost     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                sel_nx = '0;
                if (result_valid) begin
                    state_nx = room ? ST_SWEEP : ST_STALL;
                end
            end
            ST_STALL: begin
                lost = result_valid;
                if (room) begin
                    state_nx = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                lost = result_valid;
                push = 1'b1;
                if (sel_q == SEL_LAST) begin
                    state_nx = ST_IDLE;
                    sel_nx   = '0;
                end else begin
                    sel_nx = sel_q + 1'b1;
                end
            end
            default: begin
                state_nx = ST_IDLE;
                sel_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state    <= ST_IDLE;
            sel_q    <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nx;
            sel_q <= sel_nx;
            if (lost) begin
                overflow <= 1'b1;
            end
        end
    end

    assign hold  = (state != ST_IDLE);
    assign P_sel = (state == ST_SWEEP) ? sel_q : '0;

    matrix_result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (P_WIDTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (clear),
        .push     (push),
        .wr_data  (P_out),
        .pop      (rd_ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .count    (count)
    );

endmodule

// File: doc/matrix_result_collector.md
MATRIX_RESULT_COLLECTOR -- requirements
Module: matrix_result_collector

Interface
REQ-001 SHALL have parameter DEPTH, default 16: result FIFO depth in words, power of two, at least 4.
REQ-002 SHALL have parameter P_WIDTH, default 18: width of one product word.
REQ-003 SHALL have parameter NUM_P, default 4: products per result set, swept via P_sel.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port result_valid, input, 1: single-cycle pulse from matrixTOP marking a complete result set.
REQ-007 SHALL have port P_out, input, P_WIDTH: product word from matrixTOP, combinational from P_sel.
REQ-008 SHALL have port P_sel, output, 2: product index driven to matrixTOP.
REQ-009 SHALL have port hold, output, 1: high when matrixTOP must keep its results stable.
REQ-010 SHALL have port clear, input, 1: synchronous flush of FIFO and flags.
REQ-011 SHALL have port rd_data, output, P_WIDTH: FIFO head word, show-ahead.
REQ-012 SHALL have port rd_valid, output, 1: rd_data holds a valid word.
REQ-013 SHALL have port rd_ready, input, 1: consumer accepts rd_data.
REQ-014 SHALL have port count, output, log2(DEPTH)+1: FIFO occupancy.
REQ-015 SHALL have port overflow, output, 1: sticky flag set when a result_valid is lost.

Function
REQ-016 SHALL implement FSM states IDLE, STALL and SWEEP.
REQ-017 IDLE: on result_valid with DEPTH-count >= NUM_P, SHALL go to SWEEP, counting free space before any same-cycle read.
REQ-018 IDLE: on result_valid with DEPTH-count < NUM_P, SHALL go to STALL.
REQ-019 STALL: SHALL go to SWEEP in the first cycle in which DEPTH-count >= NUM_P.
REQ-020 SWEEP: SHALL drive P_sel = 0,1,...,NUM_P-1 on consecutive cycles and write P_out into the FIFO in each of those cycles.
REQ-021 SWEEP: SHALL return to IDLE after the write with P_sel = NUM_P-1.
REQ-022 hold SHALL be high exactly while the state is STALL or SWEEP.
REQ-023 P_sel SHALL be 0 in IDLE and in STALL.
REQ-024 Latency: for a result_valid in cycle N with space available, words SHALL be written in cycles N+1..N+NUM_P and rd_valid SHALL be first high in cycle N+2.
REQ-025 A result_valid arriving in STALL or SWEEP SHALL be ignored and SHALL set overflow.
REQ-026 A FIFO pop SHALL occur when rd_valid and rd_ready are both high; rd_ready with rd_valid low SHALL have no effect.
REQ-027 rd_valid SHALL equal (count != 0).
REQ-028 rd_data SHALL equal mem[rd_ptr].
REQ-029 A push and a pop in the same cycle SHALL leave count unchanged, including when count = DEPTH.
REQ-030 Read and write pointers SHALL wrap modulo DEPTH.
REQ-031 The FSM SHALL never push while count = DEPTH; this is guaranteed by the free-space check.
REQ-032 clear SHALL zero the pointers, count and overflow, force IDLE, and override any same-cycle result_valid, push or pop.

Reset
REQ-033 On rst, the state SHALL be IDLE; P_sel, hold, rd_valid, count and overflow SHALL be 0; the pointers SHALL be 0.
REQ-034 FIFO memory contents SHALL NOT be reset.
REQ-035 rst asserted mid-SWEEP SHALL abort the sweep; any partial set already written SHALL be discarded by the pointer reset.
REQ-036 rst SHALL have priority over clear.

Structure
REQ-037 The shared package matrix_pkg SHALL hold P_WIDTH, NUM_P and the collector state encoding.
REQ-038 The FIFO SHALL be the sub-module matrix_result_fifo (DEPTH, WIDTH; push, pop, count, show-ahead data).
REQ-039 The FSM and the P_sel counter SHALL reside in matrix_result_collector.

Verification
REQ-040 Single set: result_valid pulse with P_out = 0x00011,0x00022,0x00033,0x00044 for P_sel 0..3 -> count = 4 at N+5, reads in order 0x00011..0x00044, hold high for 4 cycles.
REQ-041 Fill: four sets with rd_ready = 0 -> count = 16; a fifth result_valid -> STALL with hold high; two pops -> still STALL; a fourth pop -> SWEEP begins next cycle.
REQ-042 Overflow: result_valid during SWEEP -> overflow = 1 and only 4 words written; clear -> overflow = 0, count = 0.
REQ-043 Simultaneous: rd_ready held high during a sweep starting from count = 2 -> count follows 2,2,2,2,2 through the sweep and the data order is preserved across pointer wrap.
REQ-044 Reset mid-SWEEP at P_sel = 2 -> next cycle P_sel = 0, hold = 0, count = 0, rd_valid = 0.
REQ-045 Idle read: rd_ready = 1 with count = 0 -> count stays 0 and the pointers do not move.
